// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply waits MUL_CYCLES cycles; divide is restoring, one bit per cycle, plus a sign-fix cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntMax = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             msigned_q, msigned_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic               accept;
    logic               mul_last;
    logic               div_last;
    logic               sdiv;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic [WIDTH-1:0]   fix_quo, fix_rem;

    assign accept   = start && (state_q == StIdle);
    assign mul_last = (cnt_q == CW'(MUL_CYCLES - 1));
    assign div_last = (cnt_q == CW'(WIDTH - 1));
    assign sdiv     = (op == OpDiv);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMult || op == OpMultu) begin
                        state_d = StMul;
                    end else if (op == OpDiv || op == OpDivu) begin
                        state_d = StDiv;
                    end
                end
            end
            StMul:   if (mul_last) state_d = StIdle;
            StDiv:   if (div_last) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath arithmetic
    always_comb begin
        mul_a     = msigned_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
        mul_b     = msigned_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
        product   = mul_a * mul_b;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        fix_quo   = qneg_q ? -quo_q : quo_q;
        fix_rem   = rneg_q ? -rem_q : rem_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        msigned_d = msigned_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    unique case (op)
                        OpMult, OpMultu: begin
                            opa_d     = A;
                            opb_d     = B;
                            msigned_d = (op == OpMult);
                        end
                        OpDiv, OpDivu: begin
                            // Divide on magnitudes; opa keeps the raw dividend for div-by-zero.
                            opa_d  = A;
                            opb_d  = (sdiv && B[WIDTH-1]) ? -B : B;
                            quo_d  = (sdiv && A[WIDTH-1]) ? -A : A;
                            rem_d  = '0;
                            qneg_d = sdiv && (A[WIDTH-1] ^ B[WIDTH-1]);
                            rneg_d = sdiv && A[WIDTH-1];
                            dz_d   = (B == '0);
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                cnt_d = cnt_q + CW'(1);
                if (mul_last) begin
                    cnt_d        = '0;
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                end
            end
            StDiv: begin
                cnt_d = div_last ? '0 : cnt_q + CW'(1);
                if (!rem_diff[WIDTH]) begin
                    rem_d = rem_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            StFix: begin
                cnt_d  = '0;
                done_d = 1'b1;
                if (dz_q) begin
                    lo_d = '1;
                    hi_d = opa_q;
                end else begin
                    lo_d = fix_quo;
                    hi_d = fix_rem;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            msigned_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            msigned_q <= msigned_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit (WIDTH=32, MUL_CYCLES=5).
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op and follow it to completion; lat=0 means no busy phase expected.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        logic [31:0] phi, plo;
        int cycles;
        bit stable;
        @(negedge clk);
        phi   = hi;
        plo   = lo;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 3'b000;
        if (lat == 0) begin
            check({name, " busy"}, {63'd0, busy}, 64'd0);
            check({name, " done"}, {63'd0, done}, 64'd0);
        end else begin
            check({name, " busy at accept"}, {63'd0, busy}, 64'd1);
            check({name, " done at accept"}, {63'd0, done}, 64'd0);
            cycles = 0;
            stable = 1'b1;
            while (!done && cycles < 200) begin
                if (!busy || hi !== phi || lo !== plo) stable = 1'b0;
                @(posedge clk);
                #1;
                cycles++;
            end
            check({name, " stable while busy"}, {63'd0, stable}, 64'd1);
            check({name, " latency"}, 64'(cycles), 64'(lat));
            check({name, " busy at done"}, {63'd0, busy}, 64'd0);
        end
        check({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({name, " lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[4]  = '{3'b011, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 33};
        vecs[5]  = '{3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
        vecs[7]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[8]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 33};
        vecs[9]  = '{3'b100, 32'h00001234, 32'd0,        32'h00001234, 32'h7FFFFFFC, 0};
        vecs[10] = '{3'b101, 32'h0000ABCD, 32'd0,        32'h00001234, 32'h0000ABCD, 0};
        vecs[11] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[12] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[13] = '{3'b000, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[14] = '{3'b000, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 5};
        vecs[15] = '{3'b010, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 33};
        vecs[16] = '{3'b110, 32'hDEADBEEF, 32'd1,        32'h00000000, 32'hC0000000, 0};

        reset = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back: each op is started in the cycle the previous done is high.
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        // mthi and a second mult during a busy mult are both dropped.
        begin
            int cycles;
            @(negedge clk);
            start = 1'b1;
            op    = 3'b000;
            A     = 32'd3;
            B     = 32'd5;
            @(posedge clk);
            #1;
            start  = 1'b0;
            cycles = 0;
            @(negedge clk);
            start = 1'b1;
            op    = 3'b100;
            A     = 32'h00001234;
            @(posedge clk);
            #1;
            cycles++;
            check("mthi while busy ignored", {32'd0, hi}, 64'd0);
            @(negedge clk);
            op = 3'b001;
            A  = 32'hFFFFFFFF;
            B  = 32'hFFFFFFFF;
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
            while (!done && cycles < 200) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            check("busy-start latency", 64'(cycles), 64'd5);
            check("busy-start hi", {32'd0, hi}, 64'd0);
            check("busy-start lo", {32'd0, lo}, 64'd15);
        end
        run_op("late mthi", 3'b100, 32'h00001234, 32'd0, 32'h00001234, 32'd15, 0);

        // Reset partway through a divide discards everything.
        @(negedge clk);
        start = 1'b1;
        op    = 3'b010;
        A     = 32'd100;
        B     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid-div reset busy", {63'd0, busy}, 64'd0);
        check("mid-div reset done", {63'd0, done}, 64'd0);
        check("mid-div reset hi", {32'd0, hi}, 64'd0);
        check("mid-div reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("mult after reset", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        @(posedge clk);
        #1;
        check("done single pulse", {63'd0, done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
